rom_tl_slave: RTL and testbench
===============================

ROM_TL_SLAVE -- requirements
Module: rom_tl_slave

Interface
REQ-001 SHALL have parameter SRC_W, default 4: TileLink source-ID width.
REQ-002 SHALL have parameter MAX_SIZE, default 6: largest supported log2 transfer size in bytes (64 B = 8 beats).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have A-channel ports: a_valid in 1; a_ready out 1; a_opcode in 3; a_size in 3; a_source in SRC_W; a_address in 64 (ignored, stream ROM).
REQ-006 SHALL have D-channel ports: d_valid out 1; d_ready in 1; d_opcode out 3; d_size out 3; d_source out SRC_W; d_denied out 1; d_data out 64.
REQ-007 SHALL have word-stream ports from the ROM byte assembler: w_valid in 1; w_data in 64; w_ready out 1.

Function
REQ-008 SHALL implement FSM states S_IDLE, S_BEAT, S_ACK, encoded 2 bits.
REQ-009 S_IDLE SHALL drive a_ready=1; all other states a_ready=0.
REQ-010 On a_valid&&a_ready SHALL latch a_opcode, a_size, a_source into request registers.
REQ-011 Accepted Get (opcode 4) SHALL go to S_BEAT with beat total = 1 if size<=3, else 1<<(size-3).
REQ-012 Size > MAX_SIZE SHALL be clamped to MAX_SIZE for beat counting; d_size SHALL echo the latched (unclamped) a_size.
REQ-013 Accepted non-Get SHALL go to S_ACK.
REQ-014 In S_BEAT, w_ready SHALL be combinational: (~d_valid || d_ready) && (words_loaded < beat total).
REQ-015 On w_valid&&w_ready SHALL register d_data<=w_data, d_valid<=1, words_loaded+1.
REQ-016 On d_valid&&d_ready with no simultaneous load SHALL clear d_valid; simultaneous accept+load SHALL keep d_valid=1 with new data (no bubble).
REQ-017 d_opcode SHALL be 1 (AccessAckData) in S_BEAT, d_denied=0.
REQ-018 Final beat accepted on D (d_valid&&d_ready, beats_sent == total-1) SHALL return to S_IDLE next cycle; counters cleared.
REQ-019 Latency: Get accepted at cycle N with w_valid high SHALL give earliest d_valid at N+2; back-to-back beats at one per cycle when w_valid and d_ready stay high.
REQ-020 w_valid low mid-burst SHALL stall without dropping or duplicating words; d_ready low SHALL hold d_data/d_valid stable.
REQ-021 In S_ACK SHALL drive d_valid=1, d_opcode=0 (AccessAck), d_data=0; on d_ready return to S_IDLE; w_ready=0.
REQ-022 d_source SHALL equal latched a_source for every response beat.
REQ-023 New A request SHALL NOT be accepted until the previous response completes (one outstanding).

Reset
REQ-024 rst_n low SHALL asynchronously force state S_IDLE, d_valid=0, d_data=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, counters 0.
REQ-025 Reset mid-burst SHALL abandon the transaction; words already consumed from the stream are lost; a_ready=1 first cycle after release.

Configuration
REQ-026 Macro ROM_TL_DENY_EN defined: non-Get requests SHALL respond AccessAck with d_denied=1 (ROM is read-only error).
REQ-027 Macro ROM_TL_DENY_EN undefined: non-Get requests SHALL respond AccessAck with d_denied=0, write data silently discarded.

Verification
REQ-028 Get size 3 source 5, w_data=0x1122334455667788, d_ready=1 -> one beat, d_opcode=1, d_source=5, d_data matches, d_valid first at N+2.
REQ-029 Get size 6, eight words 0..7 streamed, d_ready=1 -> eight consecutive beats data 0..7, then a_ready=1.
REQ-030 Get size 5, d_ready toggled 1/0 each cycle, w_valid gapped -> exactly 4 beats in order, data stable while stalled.
REQ-031 PutFullData (opcode 0) source 2 -> single AccessAck, d_source=2, w_ready never asserted; d_denied=1 with ROM_TL_DENY_EN, 0 without.
REQ-032 rst_n pulsed low during beat 3 of size-6 Get -> d_valid=0 immediately, S_IDLE, next Get served normally.
REQ-033 Get size 7 with MAX_SIZE=6 -> 8 beats, d_size=7.

Source files
------------

// File: rtl/rom_tl_slave.sv
// TileLink-UL slave that answers Get requests with words pulled from a ROM word stream; one request outstanding.
// Latency: Get handshake in cycle N gives first d_valid in cycle N+2, then one beat per cycle while w_valid and d_ready stay high.
// Backpressure: d_ready low holds d_valid/d_data stable and deasserts w_ready. a_ready is high only in S_IDLE. Macro ROM_TL_DENY_EN makes non-Get requests return denied.
module rom_tl_slave #(
  parameter int SRC_W    = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  // A channel
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [63:0]      a_address,
  // D channel
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic             d_denied,
  output logic [63:0]      d_data,
  // ROM word stream
  input  logic             w_valid,
  input  logic [63:0]      w_data,
  output logic             w_ready
);

  localparam logic [2:0] OP_GET     = 3'd4;
  localparam logic [2:0] OP_ACK     = 3'd0;
  localparam logic [2:0] OP_ACKDATA = 3'd1;
  localparam int         BEAT_W     = (MAX_SIZE > 3) ? MAX_SIZE - 1 : 2;

`ifdef ROM_TL_DENY_EN
  localparam logic DENY_NONGET = 1'b1;
`else
  localparam logic DENY_NONGET = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e              state_q;
  logic [2:0]          req_opcode_q;
  logic [2:0]          req_size_q;
  logic [SRC_W-1:0]    req_source_q;
  logic [BEAT_W-1:0]   beat_total_q;
  logic [BEAT_W-1:0]   beat_total_d;
  logic [BEAT_W-1:0]   words_loaded_q;
  logic [BEAT_W-1:0]   beats_sent_q;
  logic                d_valid_q;
  logic [2:0]          d_opcode_q;
  logic                d_denied_q;
  logic [63:0]         d_data_q;
  logic [2:0]          size_eff;
  logic                w_fire;
  logic                d_fire;
  logic                last_beat;
  logic                unused_addr;

  // The address is irrelevant: the ROM is consumed as a stream.
  assign unused_addr = ^a_address;

  // Oversized requests are served as MAX_SIZE bursts; d_size still echoes the request.
  always_comb begin
    size_eff = a_size;
    if (int'(a_size) > MAX_SIZE) size_eff = 3'(MAX_SIZE);
    if (size_eff <= 3'd3) beat_total_d = BEAT_W'(1);
    else                  beat_total_d = BEAT_W'(1) << (size_eff - 3'd3);
  end

  assign a_ready   = (state_q == S_IDLE);
  assign w_ready   = (state_q == S_BEAT) && (req_opcode_q == OP_GET) &&
                     (!d_valid_q || d_ready) && (words_loaded_q < beat_total_q);
  assign w_fire    = w_valid && w_ready;
  assign d_fire    = d_valid_q && d_ready;
  assign last_beat = (beats_sent_q == beat_total_q - BEAT_W'(1));

  assign d_valid  = d_valid_q;
  assign d_opcode = d_opcode_q;
  assign d_size   = req_size_q;
  assign d_source = req_source_q;
  assign d_denied = d_denied_q;
  assign d_data   = d_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      req_opcode_q   <= '0;
      req_size_q     <= '0;
      req_source_q   <= '0;
      beat_total_q   <= '0;
      words_loaded_q <= '0;
      beats_sent_q   <= '0;
      d_valid_q      <= 1'b0;
      d_opcode_q     <= '0;
      d_denied_q     <= 1'b0;
      d_data_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (a_valid) begin
            req_opcode_q   <= a_opcode;
            req_size_q     <= a_size;
            req_source_q   <= a_source;
            words_loaded_q <= '0;
            beats_sent_q   <= '0;
            if (a_opcode == OP_GET) begin
              beat_total_q <= beat_total_d;
              d_opcode_q   <= OP_ACKDATA;
              d_denied_q   <= 1'b0;
              state_q      <= S_BEAT;
            end else begin
              beat_total_q <= BEAT_W'(1);
              d_valid_q    <= 1'b1;
              d_opcode_q   <= OP_ACK;
              d_denied_q   <= DENY_NONGET;
              d_data_q     <= '0;
              state_q      <= S_ACK;
            end
          end
        end

        S_BEAT: begin
          // A load in the same cycle as a D accept replaces the beat without a bubble.
          if (w_fire) begin
            d_data_q       <= w_data;
            d_valid_q      <= 1'b1;
            words_loaded_q <= words_loaded_q + BEAT_W'(1);
          end else if (d_fire) begin
            d_valid_q <= 1'b0;
          end
          if (d_fire) begin
            if (last_beat) begin
              state_q        <= S_IDLE;
              beats_sent_q   <= '0;
              words_loaded_q <= '0;
              d_valid_q      <= 1'b0;
            end else begin
              beats_sent_q <= beats_sent_q + BEAT_W'(1);
            end
          end
        end

        S_ACK: begin
          if (d_ready) begin
            d_valid_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          d_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_tl_slave.sv
// Randomized bench for rom_tl_slave: a transaction-level model predicts every D beat from the request and the words fed in.
module tb_rom_tl_slave;
  localparam int SRC_W = 4;
`ifdef ROM_TL_DENY_EN
  localparam logic EXP_DENY = 1'b1;
`else
  localparam logic EXP_DENY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid, a_ready;
  logic [2:0]       a_opcode, a_size;
  logic [SRC_W-1:0] a_source;
  logic [63:0]      a_address;
  logic             d_valid, d_ready;
  logic [2:0]       d_opcode, d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_denied;
  logic [63:0]      d_data;
  logic             w_valid, w_ready;
  logic [63:0]      w_data;

  always #5 clk = ~clk;

  rom_tl_slave #(.SRC_W(SRC_W), .MAX_SIZE(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready)
  );

  typedef struct {
    logic [2:0]       op;
    logic [2:0]       size;
    logic [SRC_W-1:0] src;
    logic             den;
    logic [63:0]      data;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] wq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit busy = 0, cur_get = 0, req_pend = 0, lat_chk = 0, lat_pend = 0, prev_stall = 0;
  logic [2:0]       rq_op = 3'd4, rq_size = 3'd0;
  logic [SRC_W-1:0] rq_src = '0;
  logic [63:0]      prev_data = '0, word_base = '0;
  int w_mode = 0, d_mode = 0, word_mode = 0;
  int nbeats = 0, first_fire = 0, last_fire = 0, a_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Number of beats implied by a request: bytes = 2^min(size,6), 8 bytes per beat, at least one.
  function automatic int beats_for(input int size);
    int sz, nbytes;
    sz = (size > 6) ? 6 : size;
    nbytes = 1 << sz;
    return (nbytes < 8) ? 1 : nbytes / 8;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    wq.delete();
    busy = 0; req_pend = 0; lat_pend = 0; prev_stall = 0;
  endtask

  task automatic step();
    beat_t e;
    logic [63:0] word;
    @(negedge clk);
    cyc++;
    a_valid   = req_pend;
    a_opcode  = rq_op;
    a_size    = rq_size;
    a_source  = rq_src;
    a_address = {$urandom, $urandom};
    case (w_mode)
      0:       w_valid = 1'b1;
      1:       w_valid = ($urandom_range(0, 1) == 1);
      default: w_valid = ((cyc % 3) != 0);
    endcase
    w_data = (wq.size() > 0) ? wq[0] : 64'hDEAD_BEEF_0BAD_F00D;
    case (d_mode)
      0:       d_ready = 1'b1;
      1:       d_ready = ($urandom_range(0, 1) == 1);
      default: d_ready = ((cyc % 2) == 0);
    endcase
    #1;
    if (prev_stall) begin
      check_eq("stall_vld", d_valid, 1);
      check_eq("stall_dat", d_data, prev_data);
    end
    check_eq("a_ready", a_ready, !busy);
    if (busy && !cur_get) check_eq("w_ready_ack", w_ready, 0);
    if (lat_pend && d_valid) begin
      if (lat_chk) check_eq("latency", 64'(cyc - a_cyc), 2);
      lat_pend = 0;
    end
    if (w_valid && w_ready) begin
      if (wq.size() == 0) check_eq("w_extra", 1, 0);
      else void'(wq.pop_front());
    end
    if (d_valid && d_ready) begin
      if (exp_q.size() == 0) check_eq("d_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("d_data", d_data, e.data);
        check_eq("d_opcode", d_opcode, e.op);
        check_eq("d_size", d_size, e.size);
        check_eq("d_source", d_source, e.src);
        check_eq("d_denied", d_denied, e.den);
        if (nbeats == 0) first_fire = cyc;
        last_fire = cyc;
        nbeats++;
        if (exp_q.size() == 0) busy = 0;
      end
    end
    if (a_valid && a_ready) begin
      req_pend = 0; busy = 1; lat_pend = 1; a_cyc = cyc; nbeats = 0;
      cur_get = (a_opcode == 3'd4);
      if (cur_get) begin
        for (int i = 0; i < beats_for(int'(a_size)); i++) begin
          case (word_mode)
            0:       word = {$urandom, $urandom};
            1:       word = 64'(i);
            default: word = word_base;
          endcase
          wq.push_back(word);
          exp_q.push_back('{op: 3'd1, size: a_size, src: a_source, den: 1'b0, data: word});
        end
      end else begin
        exp_q.push_back('{op: 3'd0, size: a_size, src: a_source, den: EXP_DENY, data: 64'd0});
      end
    end
    prev_stall = d_valid && !d_ready;
    prev_data  = d_data;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [2:0] size, input logic [SRC_W-1:0] src);
    rq_op = op; rq_size = size; rq_src = src; req_pend = 1;
    for (int i = 0; i < 400 && (req_pend || busy); i++) step();
    if (req_pend || busy) begin
      check_eq("timeout", 1, 0);
      clear_model();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0;
    d_ready = 0; w_valid = 0; w_data = 0;
    #1;
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_d_data", d_data, 0);
    check_eq("rst_d_opcode", d_opcode, 0);
    check_eq("rst_d_size", d_size, 0);
    check_eq("rst_d_source", d_source, 0);
    check_eq("rst_d_denied", d_denied, 0);
    check_eq("rst_a_ready", a_ready, 1);
    check_eq("rst_w_ready", w_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single-beat Get with latency check.
    w_mode = 0; d_mode = 0; word_mode = 2; word_base = 64'h1122334455667788; lat_chk = 1;
    run_txn(3'd4, 3'd3, 4'd5);
    check_eq("beats_sz3", nbeats, 1);
    lat_chk = 0;

    // 64-byte burst, words 0..7, must stream back to back.
    word_mode = 1;
    run_txn(3'd4, 3'd6, 4'd1);
    check_eq("beats_sz6", nbeats, 8);
    check_eq("b2b_span", 64'(last_fire - first_fire), 7);
    step();

    // 32-byte burst with toggling d_ready and gapped stream.
    w_mode = 1; d_mode = 2; word_mode = 0;
    run_txn(3'd4, 3'd5, 4'd3);
    check_eq("beats_sz5", nbeats, 4);

    // PutFullData answered with a single AccessAck.
    w_mode = 1; d_mode = 0;
    run_txn(3'd0, 3'd3, 4'd2);
    check_eq("beats_put", nbeats, 1);

    // Reset in the middle of a size-6 burst.
    w_mode = 0; d_mode = 0; word_mode = 1;
    rq_op = 3'd4; rq_size = 3'd6; rq_src = 4'd6; req_pend = 1;
    for (int i = 0; i < 60 && !(busy && nbeats >= 3); i++) step();
    check_eq("rst_reach", nbeats, 3);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_d_valid", d_valid, 0);
    check_eq("mid_rst_a_ready", a_ready, 1);
    check_eq("mid_rst_d_data", d_data, 0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    word_mode = 0;
    run_txn(3'd4, 3'd3, 4'd7);
    check_eq("beats_after_rst", nbeats, 1);

    // Oversized request is clamped for beat count only.
    w_mode = 1; d_mode = 1;
    run_txn(3'd4, 3'd7, 4'd9);
    check_eq("beats_sz7", nbeats, 8);

    // Random mix of opcodes, sizes and flow-control patterns.
    for (int t = 0; t < 30; t++) begin
      logic [2:0] op;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: op = 3'd4;
        4:          op = 3'd0;
        5:          op = 3'd1;
        6:          op = 3'd2;
        default:    op = 3'd5;
      endcase
      w_mode = $urandom_range(0, 2);
      d_mode = $urandom_range(0, 2);
      run_txn(op, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    step();
    check_eq("final_exp_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
